// File: rtl/lc3b_pkg.sv
// Shared LC-3b write-back types: register geometry, the buffered result entry
// and the N/Z/P encoder used when a result retires.
package lc3b_pkg;

    localparam int REG_W      = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dr;
        logic [REG_W-1:0]      data;
        logic                  setcc;
    } wb_entry_t;

    // Returns {n, z, p}; exactly one bit is set for any data value.
    function automatic logic [2:0] calc_nzp(input logic [REG_W-1:0] data);
        logic n_bit;
        logic z_bit;
        n_bit = data[REG_W-1];
        z_bit = (data == '0);
        return {n_bit, z_bit, ~n_bit & ~z_bit};
    endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// Producer-side result bus of the write-back sequencer: master is the result
// producer, slave is regfile_wb.
interface regfile_wb_if;
    import lc3b_pkg::*;

    // A result transfers on every rising edge where wb_valid && wb_ready.
    // wb_ready comes from registered state only; wb_stall is a sideband that
    // blocks retirement and does not take part in the handshake.
    logic                  wb_valid;
    logic                  wb_ready;
    logic [REG_ADDR_W-1:0] wb_dr;
    logic [REG_W-1:0]      wb_data;
    logic                  wb_setcc;
    logic                  wb_stall;

    modport master (
        output wb_valid, wb_dr, wb_data, wb_setcc, wb_stall,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_dr, wb_data, wb_setcc, wb_stall,
        output wb_ready
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order result FIFO for regfile_wb. Besides the head entry it exposes the
// per-slot valid bits and destination fields so the top can build the hazard mask.
module wb_fifo
    import lc3b_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                             clk_50,
    input  logic                             reset_n,
    input  logic                             push,
    input  wb_entry_t                        push_entry,
    input  logic                             pop,
    output wb_entry_t                        head,
    output logic [CW-1:0]                    count,
    output logic [DEPTH-1:0]                 valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_dr
);

    wb_entry_t      mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a slot only matters while its valid bit is set.
    always_ff @(posedge clk_50) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        logic [AW-1:0] offset;
        offset = '0;
        valid  = '0;
        ent_dr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset    = AW'(i) - rd_ptr;
            valid[i]  = ({1'b0, offset} < count);
            ent_dr[i] = mem[i].dr;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// LC-3b write-back sequencer: buffers results, retires one per cycle onto the
// register-file write port, owns N/Z/P and publishes the pending-write mask.
// Optional feature: define LC3B_WB_BYPASS_EN to let a result arriving at an
// empty, unstalled sequencer skip the FIFO and retire on its push edge.
module regfile_wb
    import lc3b_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk_50,
    input  logic                  reset_n,
    regfile_wb_if.slave           wb,
    output logic                  ldreg,
    output logic [REG_ADDR_W-1:0] dr,
    output logic [REG_W-1:0]      reg_in,
    output logic                  n,
    output logic                  z,
    output logic                  p,
    output logic [NUM_REGS-1:0]   pending,
    output logic [CW-1:0]         count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    wb_entry_t                        in_entry;
    wb_entry_t                        head;
    wb_entry_t                        ret_entry;
    logic                             accept;
    logic                             bypass;
    logic                             fifo_push;
    logic                             fifo_pop;
    logic                             retire;
    logic [DEPTH-1:0]                 slot_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] slot_dr;

    assign wb.wb_ready = (count < FULL);
    assign accept      = wb.wb_valid && wb.wb_ready;
    assign in_entry    = '{dr: wb.wb_dr, data: wb.wb_data, setcc: wb.wb_setcc};
    assign fifo_pop    = (count != '0) && !wb.wb_stall;

`ifdef LC3B_WB_BYPASS_EN
    assign bypass = accept && (count == '0) && !wb.wb_stall;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = accept && !bypass;
    assign retire    = fifo_pop || bypass;
    assign ret_entry = fifo_pop ? head : in_entry;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_50     (clk_50),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_entry (in_entry),
        .pop        (fifo_pop),
        .head       (head),
        .count      (count),
        .valid      (slot_valid),
        .ent_dr     (slot_dr)
    );

    // Output stage: dr/reg_in hold between pulses; codes move on the pop edge.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            ldreg     <= 1'b0;
            dr        <= '0;
            reg_in    <= '0;
            {n, z, p} <= 3'b010;
        end else begin
            ldreg <= retire;
            if (retire) begin
                dr     <= ret_entry.dr;
                reg_in <= ret_entry.data;
                if (ret_entry.setcc) {n, z, p} <= calc_nzp(ret_entry.data);
            end
        end
    end

    // A register stays pending until its final write has had its ldreg cycle.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) pending[slot_dr[i]] = 1'b1;
        end
        if (ldreg) pending[dr] = 1'b1;
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_regfile_wb;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ldreg;
  logic [2:0]    dr;
  logic [15:0]   reg_in;
  logic          n, z, p;
  logic [7:0]    pending;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  regfile_wb_if wb_bus ();

  regfile_wb #(.DEPTH(DEPTH)) dut (
    .clk_50  (clk),
    .reset_n (reset_n),
    .wb      (wb_bus),
    .ldreg   (ldreg),
    .dr      (dr),
    .reg_in  (reg_in),
    .n       (n),
    .z       (z),
    .p       (p),
    .pending (pending),
    .count   (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: expected queue of {setcc, dr, data} plus output stage
  logic [19:0] exp_q[$];
  logic        m_ldreg = 1'b0;
  logic [2:0]  m_dr = '0;
  logic [15:0] m_in = '0;
  logic [2:0]  m_nzp = 3'b010;
  logic        model_live = 1'b0;

  task automatic model_retire(input logic [19:0] e);
    m_ldreg = 1'b1;
    m_dr    = e[18:16];
    m_in    = e[15:0];
    if (e[19]) begin
      if (e[15])              m_nzp = 3'b100;
      else if (e[15:0] == 0)  m_nzp = 3'b010;
      else                    m_nzp = 3'b001;
    end
  endtask

  function automatic logic [7:0] model_pending();
    logic [7:0] mask;
    mask = '0;
    foreach (exp_q[i]) mask[exp_q[i][18:16]] = 1'b1;
    if (m_ldreg) mask[m_dr] = 1'b1;
    return mask;
  endfunction

  always @(posedge clk) begin : model
    logic        acc;
    logic [19:0] incoming;
    if (!reset_n) begin
      exp_q.delete();
      m_ldreg    = 1'b0;
      m_dr       = '0;
      m_in       = '0;
      m_nzp      = 3'b010;
      model_live = 1'b1;
    end else if (model_live) begin
      acc      = wb_bus.wb_valid && (exp_q.size() < DEPTH);
      incoming = {wb_bus.wb_setcc, wb_bus.wb_dr, wb_bus.wb_data};
      if (exp_q.size() != 0 && !wb_bus.wb_stall) begin
        model_retire(exp_q.pop_front());
      end
`ifdef LC3B_WB_BYPASS_EN
      else if (acc && exp_q.size() == 0 && !wb_bus.wb_stall) begin
        model_retire(incoming);
        acc = 1'b0;
      end
`endif
      else begin
        m_ldreg = 1'b0;
      end
      if (acc) exp_q.push_back(incoming);
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (model_live) begin
      check("count",   32'(count),           32'(exp_q.size()));
      check("ready",   32'(wb_bus.wb_ready), 32'(exp_q.size() < DEPTH));
      check("ldreg",   32'(ldreg),           32'(m_ldreg));
      check("dr",      32'(dr),              32'(m_dr));
      check("reg_in",  32'(reg_in),          32'(m_in));
      check("nzp",     32'({n, z, p}),       32'(m_nzp));
      check("pending", 32'(pending),         32'(model_pending()));
    end
  end

  // driver
  task automatic drive(input logic v, input logic [2:0] d, input logic [15:0] dat,
                       input logic sc, input logic st, input logic rn);
    wb_bus.wb_valid = v;
    wb_bus.wb_dr    = d;
    wb_bus.wb_data  = dat;
    wb_bus.wb_setcc = sc;
    wb_bus.wb_stall = st;
    reset_n         = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    wb_bus.wb_valid = 1'b1;
    wb_bus.wb_dr    = 3'd2;
    wb_bus.wb_data  = 16'h1234;
    wb_bus.wb_setcc = 1'b1;
    wb_bus.wb_stall = 1'b0;

    // reset with a result offered: nothing is captured
    drive(1'b1, 3'd2, 16'h1234, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd2, 16'h1234, 1'b1, 1'b0, 1'b0);
    check("rst_count",   32'(count),           32'd0);
    check("rst_ready",   32'(wb_bus.wb_ready), 32'd1);
    check("rst_ldreg",   32'(ldreg),           32'd0);
    check("rst_pending", 32'(pending),         32'h00);
    check("rst_nzp",     32'({n, z, p}),       32'b010);

    // single write R3 = 8001 with setcc
    drive(1'b1, 3'd3, 16'h8001, 1'b1, 1'b0, 1'b1);
`ifdef LC3B_WB_BYPASS_EN
    check("sw_ldreg",   32'(ldreg),     32'd1);
    check("sw_dr",      32'(dr),        32'd3);
    check("sw_reg_in",  32'(reg_in),    32'h8001);
    check("sw_nzp",     32'({n, z, p}), 32'b100);
    check("sw_pend",    32'(pending),   32'h08);
    idle(1);
    check("sw_pend_clr", 32'(pending),  32'h00);
`else
    check("sw_pend",     32'(pending),  32'h08);
    check("sw_ldreg0",   32'(ldreg),    32'd0);
    idle(1);
    check("sw_ldreg",    32'(ldreg),     32'd1);
    check("sw_dr",       32'(dr),        32'd3);
    check("sw_reg_in",   32'(reg_in),    32'h8001);
    check("sw_nzp",      32'({n, z, p}), 32'b100);
    check("sw_pend_hold", 32'(pending),  32'h08);
    idle(1);
    check("sw_pend_clr", 32'(pending),   32'h00);
    check("sw_ldreg_off", 32'(ldreg),    32'd0);
`endif
    idle(2);

    // fill under stall: five offers, four accepted
    for (int i = 0; i < 5; i++) drive(1'b1, 3'(i), 16'h1000 + 16'(i), 1'b0, 1'b1, 1'b1);
    check("fill_count", 32'(count),           32'd4);
    check("fill_ready", 32'(wb_bus.wb_ready), 32'd0);
    check("fill_pend",  32'(pending),         32'h0F);
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, 3'd4, 16'h1004, 1'b0, 1'b0, 1'b1);
      check("fill_ldreg", 32'(ldreg),  32'd1);
      check("fill_dr",    32'(dr),     32'(i));
      check("fill_data",  32'(reg_in), 32'h1000 + 32'(i));
    end
    idle(1);
    check("fill_r4_dr",   32'(dr),     32'd4);
    check("fill_r4_data", 32'(reg_in), 32'h1004);
    idle(2);

    // simultaneous push and pop at count 2
    drive(1'b1, 3'd5, 16'h0A05, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 3'd6, 16'h0A06, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 3'd7, 16'h0A07, 1'b0, 1'b0, 1'b1);
    check("pp_count", 32'(count), 32'd2);
    check("pp_dr0",   32'(dr),    32'd5);
    idle(1);
    check("pp_dr1",   32'(dr),    32'd6);
    idle(1);
    check("pp_dr2",   32'(dr),    32'd7);
    check("pp_data2", 32'(reg_in), 32'h0A07);
    idle(2);

    // same register twice, codes in order
    drive(1'b1, 3'd1, 16'h0011, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 3'd1, 16'h0000, 1'b1, 1'b0, 1'b1);
    check("same_ldreg1", 32'(ldreg),     32'd1);
    check("same_nzp1",   32'({n, z, p}), 32'b001);
    check("same_pend1",  32'(pending),   32'h02);
    idle(1);
    check("same_ldreg2", 32'(ldreg),     32'd1);
    check("same_data2",  32'(reg_in),    32'h0000);
    check("same_nzp2",   32'({n, z, p}), 32'b010);
    check("same_pend2",  32'(pending),   32'h02);
    idle(1);
    check("same_pend3",  32'(pending),   32'h00);
    idle(1);

    // reset mid-drain with count 3 and ldreg high
    for (int i = 0; i < 4; i++) drive(1'b1, 3'(i + 2), 16'hF000 + 16'(i), 1'b1, 1'b1, 1'b1);
    idle(1);
    check("mid_count", 32'(count), 32'd3);
    check("mid_ldreg", 32'(ldreg), 32'd1);
    drive(1'b1, 3'd6, 16'h7777, 1'b1, 1'b0, 1'b0);
    check("mid_rst_ldreg", 32'(ldreg),     32'd0);
    check("mid_rst_count", 32'(count),     32'd0);
    check("mid_rst_pend",  32'(pending),   32'h00);
    check("mid_rst_nzp",   32'({n, z, p}), 32'b010);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("mid_no_write", 32'(ldreg), 32'd0);
    end

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [15:0] rd;
      rd = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      drive($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), rd,
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 99) != 0);
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
